data_sram_resp: RTL and testbench

//  Data-memory responder on the CPU data_sram_* port (the memory end of the load/store path).

---
 rtl/data_sram_resp_if.sv | 25 ++
 rtl/data_sram_resp.sv | 128 ++++++++++++
 tb/tb_data_sram_resp.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_resp_if.sv
// Data-SRAM request/response bundle between the CPU load/store
// path and the memory responder.
interface data_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_resp.sv
// Data-memory responder: byte-masked writes and word reads on an
// internal array, with optional wait states reported via stall_req.
module data_sram_resp #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned LATENCY    = 0,
    parameter logic [31:0] BASE_ADDR  = 32'h1c000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    data_sram_resp_if.slave  bus,
    output logic             stall_req,
    output logic             addr_err
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [32:0] LIMIT =
        {1'b0, BASE_ADDR} + (33'd1 << (ADDR_WIDTH + 2));

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        aerr_q, aerr_d;

    logic [31:0] mem [DEPTH];

    logic                  req;
    logic                  in_range;
    logic                  commit;
    logic [3:0]            c_we;
    logic [31:0]           c_addr;
    logic [31:0]           c_wdata;
    logic [31:0]           c_off;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  unused_bits;

    assign req = reset && (state_q == IDLE) &&
                 bus.data_sram_en && !flush;
    assign in_range = (bus.data_sram_addr >= BASE_ADDR) &&
                      ({1'b0, bus.data_sram_addr} < LIMIT);

    // Zero latency commits straight from the bus; otherwise from the capture.
    assign c_we    = (LATENCY == 0) ? bus.data_sram_we    : we_q;
    assign c_addr  = (LATENCY == 0) ? bus.data_sram_addr  : addr_q;
    assign c_wdata = (LATENCY == 0) ? bus.data_sram_wdata : wdata_q;
    assign c_off   = c_addr - BASE_ADDR;
    assign idx     = c_off[ADDR_WIDTH+1:2];
    assign unused_bits = ^{c_off[1:0], c_off[31:ADDR_WIDTH+2]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        aerr_d    = req && !in_range;
        stall_req = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && in_range) begin
                    if (LATENCY == 0) begin
                        commit = 1'b1;
                    end else begin
                        stall_req = 1'b1;
                        we_d      = bus.data_sram_we;
                        addr_d    = bus.data_sram_addr;
                        wdata_d   = bus.data_sram_wdata;
                        cnt_d     = 4'(LATENCY - 1);
                        state_d   = (LATENCY == 1) ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    stall_req = 1'b1;
                    if (cnt_q <= 4'd1) state_d = DONE;
                    else cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                commit  = !flush;
            end
            default: state_d = IDLE;
        endcase
        if (commit && (c_we == 4'h0)) rdata_d = mem[idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'h0;
            we_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            aerr_q  <= aerr_d;
        end
    end

    // Array contents survive reset; only lanes with a set enable change.
    always_ff @(posedge clk) begin
        if (commit && reset) begin
            for (int i = 0; i < 4; i++) begin
                if (c_we[i]) mem[idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

    assign bus.data_sram_rdata = rdata_q;
    assign addr_err            = aerr_q;
endmodule

// File: tb/tb_data_sram_resp.sv
// Randomized scoreboard bench for data_sram_resp with zero and
// three-cycle latency instances sharing one reset.
module tb_data_sram_resp;
    localparam int          AW    = 6;
    localparam int          WORDS = 1 << AW;
    localparam logic [31:0] BASE  = 32'h1c000000;

    typedef enum {K_RD, K_STALL, K_AERR} kind_e;
    typedef struct {
        int          due;
        int          dut;
        kind_e       kind;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush0 = 1'b0;
    logic flush3 = 1'b0;
    logic stall0, stall3, aerr0, aerr3;

    data_sram_resp_if b0 ();
    data_sram_resp_if b3 ();

    data_sram_resp #(.ADDR_WIDTH(AW), .LATENCY(0), .BASE_ADDR(BASE)) u0 (
        .clk(clk), .reset(reset), .flush(flush0), .bus(b0),
        .stall_req(stall0), .addr_err(aerr0)
    );
    data_sram_resp #(.ADDR_WIDTH(AW), .LATENCY(3), .BASE_ADDR(BASE)) u3 (
        .clk(clk), .reset(reset), .flush(flush3), .bus(b3),
        .stall_req(stall3), .addr_err(aerr3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m0[WORDS];
    logic [31:0] m3[WORDS];
    logic [31:0] last0 = 32'h0;
    logic [31:0] last3 = 32'h0;

    function automatic void push(int due, int dut, kind_e k, logic [31:0] v);
        exp_t e;
        e.due = due; e.dut = dut; e.kind = k; e.val = v;
        q.push_back(e);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(logic [31:0] o, logic [3:0] we, logic [31:0] d);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic bit in_rng(logic [31:0] a);
        longint la, lb;
        la = longint'(a);
        lb = longint'(BASE);
        return (la >= lb) && (la < lb + 4 * WORDS);
    endfunction

    function automatic int idx_of(logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 19))
            0: return BASE - 32'd4;
            1: return BASE + 32'(4 * WORDS);
            2: return BASE - 32'd1;
            3: return $urandom();
            default: return BASE + 32'($urandom_range(0, 4 * WORDS - 1));
        endcase
    endfunction

    // Monitor: pops every expectation due this cycle.
    exp_t        e_m;
    logic [31:0] act_m;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            e_m = q.pop_front();
            if (e_m.due < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale expectation due %0d at cyc %0d", e_m.due, cyc);
            end else begin
                case (e_m.kind)
                    K_RD:    act_m = e_m.dut == 0 ? b0.data_sram_rdata : b3.data_sram_rdata;
                    K_STALL: act_m = {31'b0, e_m.dut == 0 ? stall0 : stall3};
                    default: act_m = {31'b0, e_m.dut == 0 ? aerr0 : aerr3};
                endcase
                check($sformatf("%s dut%0d", e_m.kind.name(), e_m.dut == 0 ? 0 : 3),
                      act_m, e_m.val);
            end
        end
    end

    task automatic cyc0(bit en, logic [3:0] we, logic [31:0] a, logic [31:0] wd, bit fl);
        bit acc, inr;
        int c;
        c = cyc;
        b0.data_sram_en = en; b0.data_sram_we = we;
        b0.data_sram_addr = a; b0.data_sram_wdata = wd;
        flush0 = fl;
        acc = en && !fl;
        inr = in_rng(a);
        if (acc && inr) begin
            if (we == 4'h0) last0 = m0[idx_of(a)];
            else m0[idx_of(a)] = merge(m0[idx_of(a)], we, wd);
        end
        push(c, 0, K_STALL, 32'h0);
        push(c + 1, 0, K_AERR, 32'(acc && !inr));
        push(c + 1, 0, K_RD, last0);
        @(posedge clk); #1;
    endtask

    task automatic cyc3(bit en, logic [3:0] we, logic [31:0] a, logic [31:0] wd,
                        bit fl, bit st, bit ae);
        int c;
        c = cyc;
        b3.data_sram_en = en; b3.data_sram_we = we;
        b3.data_sram_addr = a; b3.data_sram_wdata = wd;
        flush3 = fl;
        push(c, 1, K_STALL, 32'(st));
        push(c + 1, 1, K_AERR, 32'(ae));
        push(c + 1, 1, K_RD, last3);
        @(posedge clk); #1;
    endtask

    // One request on the 3-cycle instance; flush_at<0 means no flush.
    task automatic txn3(bit en, logic [3:0] we, logic [31:0] a, logic [31:0] wd, int flush_at);
        bit inr;
        int k;
        inr = in_rng(a);
        if (!en) begin
            cyc3(1'b0, we, a, wd, 1'b0, 1'b0, 1'b0);
        end else if (flush_at == 0) begin
            cyc3(1'b1, we, a, wd, 1'b1, 1'b0, 1'b0);
        end else if (!inr) begin
            cyc3(1'b1, we, a, wd, 1'b0, 1'b0, 1'b1);
        end else begin
            cyc3(1'b1, we, a, wd, 1'b0, 1'b1, 1'b0);
            for (k = 1; k <= 3; k++) begin
                if (k == flush_at) begin
                    cyc3(1'b1, 4'($urandom()), rnd_addr(), $urandom(), 1'b1, 1'b0, 1'b0);
                    break;
                end
                if (k == 3) begin
                    if (we == 4'h0) last3 = m3[idx_of(a)];
                    else m3[idx_of(a)] = merge(m3[idx_of(a)], we, wd);
                end
                cyc3(1'b1, 4'($urandom()), rnd_addr(), $urandom(), 1'b0, k < 3, 1'b0);
            end
        end
    endtask

    initial begin
        logic [31:0] a, old;
        logic [3:0]  we;
        int          sel;
        b0.data_sram_en = 1'b0; b0.data_sram_we = 4'h0;
        b0.data_sram_addr = 32'h0; b0.data_sram_wdata = 32'h0;
        b3.data_sram_en = 1'b0; b3.data_sram_we = 4'h0;
        b3.data_sram_addr = 32'h0; b3.data_sram_wdata = 32'h0;
        #2;
        check("reset rdata0", b0.data_sram_rdata, 32'h0);
        check("reset rdata3", b3.data_sram_rdata, 32'h0);
        check("reset stall0", {31'b0, stall0}, 32'h0);
        check("reset stall3", {31'b0, stall3}, 32'h0);
        check("reset aerr0", {31'b0, aerr0}, 32'h0);
        check("reset aerr3", {31'b0, aerr3}, 32'h0);
        #10 reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < WORDS; i++)
            cyc0(1'b1, 4'hf, BASE + 32'(4 * i), $urandom(), 1'b0);
        cyc0(1'b1, 4'hf, 32'h1c000010, 32'hdeadbeef, 1'b0);
        cyc0(1'b1, 4'h0, 32'h1c000010, 32'h0, 1'b0);
        cyc0(1'b1, 4'hf, 32'h1c000020, 32'h11223344, 1'b0);
        cyc0(1'b1, 4'b0100, 32'h1c000020, 32'h00aa0000, 1'b0);
        cyc0(1'b1, 4'h0, 32'h1c000020, 32'h0, 1'b0);
        cyc0(1'b1, 4'h0, 32'h1bfffffc, 32'h0, 1'b0);
        cyc0(1'b1, 4'h0, BASE + 32'(4 * WORDS), 32'h0, 1'b0);
        cyc0(1'b1, 4'h0, BASE + 32'h4, 32'h0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            we = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
            cyc0($urandom_range(0, 7) != 0, we, rnd_addr(), $urandom(),
                 $urandom_range(0, 9) == 0);
        end
        cyc0(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < WORDS; i++)
            txn3(1'b1, 4'hf, BASE + 32'(4 * i), $urandom(), -1);
        txn3(1'b1, 4'h0, BASE + 32'h8, 32'h0, -1);
        txn3(1'b1, 4'hf, BASE + 32'hc, 32'hcafef00d, 1);
        txn3(1'b1, 4'h0, BASE + 32'hc, 32'h0, -1);
        txn3(1'b1, 4'h0, 32'h1bfffffc, 32'h0, -1);
        txn3(1'b1, 4'h0, BASE + 32'(4 * WORDS), 32'h0, -1);
        for (int i = 0; i < 150; i++) begin
            we = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
            sel = $urandom_range(0, 9);
            txn3($urandom_range(0, 7) != 0, we, rnd_addr(), $urandom(),
                 sel < 4 ? sel : -1);
        end
        txn3(1'b0, 4'h0, 32'h0, 32'h0, -1);
        @(negedge clk);
        @(negedge clk);

        // Asynchronous reset in the middle of a wait state.
        a = BASE + 32'h14;
        old = m3[idx_of(a)];
        @(posedge clk); #1;
        b3.data_sram_en = 1'b1; b3.data_sram_we = 4'hf;
        b3.data_sram_addr = a; b3.data_sram_wdata = ~old;
        @(posedge clk); #1;
        check("stall in wait", {31'b0, stall3}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("async stall3", {31'b0, stall3}, 32'h0);
        check("async rdata3", b3.data_sram_rdata, 32'h0);
        check("async rdata0", b0.data_sram_rdata, 32'h0);
        b3.data_sram_en = 1'b0;
        @(posedge clk);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        last0 = 32'h0;
        last3 = 32'h0;
        txn3(1'b1, 4'h0, a, 32'h0, -1);
        txn3(1'b0, 4'h0, 32'h0, 32'h0, -1);
        @(negedge clk);
        @(negedge clk);
        check("queue drained", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
